// File: rtl/spi_master_fifo.sv
// Synchronous FIFO between the SPI register interface and the SPI controller.
// Works for any depth >= 2: pointers wrap explicitly and do not rely on a power-of-2 depth.
module spi_master_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_DEPTH     = 10,
    parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        clr_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    localparam logic [LOG_BUFFER_DEPTH:0]   FULL = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG_BUFFER_DEPTH:0]   count;
    logic                        push, pop;

    assign ready_o    = (count < FULL);
    assign valid_o    = (count != '0);
    assign elements_o = count;
    assign data_o     = mem[rd_ptr];
    assign push       = valid_i & ready_o;
    assign pop        = ready_i & valid_o;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
        end else if (clr_i) begin
            // Flush drops any same-cycle traffic but leaves storage untouched.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= valid_i & ~ready_o;
            underflow_o <= ready_i & ~valid_o;
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule
